score_display_ctrl: RTL and testbench

Sequencer that turns a binary game score into a four-digit, time-multiplexed seven-segment display. It accepts a score over a valid/ready handshake and converts it to BCD with a sequential shift-add-3 (double-dabble) engine. It then scans the four digits through one shared hex-to-segment decoder instance. It sits between game logic and the board's segment/anode pins.

---
 rtl/score_display_ctrl.sv | 155 +++++++++++++++
 tb/tb_score_display_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/score_display_ctrl.sv
// Score to 4-digit multiplexed seven-segment display: handshake capture, double-dabble BCD, scan.
// Optional SCORE_LZ_BLANK_EN blanks leading zero digits (digit 0 always shown).

module seg7_decode (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);
    always_comb begin
        seg_o = 7'b1111111;
        case (hex_i)
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            4'hF: seg_o = 7'b0001110;
            default: seg_o = 7'b1111111;
        endcase
    end
endmodule

module score_display_ctrl #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] score_in,
    input  logic        score_valid,
    input  logic        mode_hex,
    output logic        score_ready,
    output logic [6:0]  seg_out,
    output logic [3:0]  digit_en
);
    localparam int            PW     = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PS_MAX = PW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t           state_q;
    logic [13:0]      bin_q;
    logic [15:0]      bcd_q;
    logic [3:0]       step_q;
    logic [3:0][3:0]  disp_q;
    logic [PW-1:0]    ps_q;
    logic [1:0]       idx_q;
    logic [6:0]       seg_q;
    logic [3:0]       den_q;

    logic [13:0]      sat_d;
    logic [15:0]      bcd_d;
    logic [6:0]       dec_seg;
    logic             blank_d;

    assign score_ready = (state_q == IDLE);
    assign seg_out     = seg_q;
    assign digit_en    = den_q;

    assign sat_d = (score_in > 14'd9999) ? 14'd9999 : score_in;

    // add-3 correction applied before each shift
    always_comb begin
        bcd_d = bcd_q;
        for (int k = 0; k < 4; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5)
                bcd_d[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            step_q  <= '0;
            disp_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (score_valid) begin
                        if (mode_hex) begin
                            bcd_q   <= {2'b00, score_in};
                            state_q <= COMMIT;
                        end else begin
                            bin_q   <= sat_d;
                            bcd_q   <= '0;
                            step_q  <= '0;
                            state_q <= CONVERT;
                        end
                    end
                end
                CONVERT: begin
                    {bcd_q, bin_q} <= {bcd_d[14:0], bin_q, 1'b0};
                    step_q         <= step_q + 4'd1;
                    if (step_q == 4'd13)
                        state_q <= COMMIT;
                end
                COMMIT: begin
                    // all four digits change in the same edge
                    disp_q  <= bcd_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    seg7_decode u_dec (
        .hex_i (disp_q[idx_q]),
        .seg_o (dec_seg)
    );

`ifdef SCORE_LZ_BLANK_EN
    always_comb begin
        blank_d = 1'b0;
        if (idx_q != 2'd0) begin
            blank_d = 1'b1;
            for (int k = 1; k < 4; k++) begin
                if (k >= int'(idx_q) && disp_q[k] != 4'd0)
                    blank_d = 1'b0;
            end
        end
    end
`else
    assign blank_d = 1'b0;
`endif

    // enable and segments register from the same idx, so they never disagree
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_q  <= '0;
            idx_q <= '0;
            seg_q <= 7'b1111111;
            den_q <= 4'b1111;
        end else begin
            if (ps_q == PS_MAX) begin
                ps_q  <= '0;
                idx_q <= idx_q + 2'd1;
            end else begin
                ps_q  <= ps_q + PW'(1);
            end
            den_q <= ~(4'b0001 << idx_q);
            seg_q <= blank_d ? 7'b1111111 : dec_seg;
        end
    end
endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl with a short scan period.

module tb_score_display_ctrl;
    logic        clk;
    logic        rst;
    logic [13:0] score_in;
    logic        score_valid;
    logic        mode_hex;
    logic        score_ready;
    logic [6:0]  seg_out;
    logic [3:0]  digit_en;

    int checks   = 0;
    int failures = 0;
    int lc;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S7 = 7'b1111000, S9 = 7'b0010000, SA = 7'b0001000,
                           SB = 7'b0000011, SC = 7'b1000110;
`ifdef SCORE_LZ_BLANK_EN
    localparam logic [6:0] LZ = 7'b1111111;
`else
    localparam logic [6:0] LZ = S0;
`endif

    score_display_ctrl #(.SCAN_DIV(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .score_in    (score_in),
        .score_valid (score_valid),
        .mode_hex    (mode_hex),
        .score_ready (score_ready),
        .seg_out     (seg_out),
        .digit_en    (digit_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic int en2idx(input logic [3:0] en);
        case (en)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic send(input logic [13:0] s, input logic h, output int low);
        int n;
        @(negedge clk);
        score_in = s; mode_hex = h; score_valid = 1'b1;
        n = 0;
        while (!score_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", n < 100, 1);
        @(posedge clk);
        @(negedge clk);
        score_valid = 1'b0;
        low = 0;
        while (!score_ready && low < 100) begin
            low++;
            @(negedge clk);
        end
    endtask

    // e is {digit3, digit2, digit1, digit0}
    task automatic check_frame(input logic [3:0][6:0] e, input string tag);
        int k;
        repeat (17) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            k = en2idx(digit_en);
            chk({tag, "_onehot"}, k >= 0, 1);
            if (k >= 0) chk({tag, "_seg"}, seg_out, e[k]);
        end
    endtask

    task automatic sample_allowed(input logic [3:0][6:0] a, input logic [3:0][6:0] b,
                                  input logic [3:0][6:0] c);
        int k;
        logic ok;
        k  = en2idx(digit_en);
        ok = 1'b0;
        if (k >= 0) ok = (seg_out === a[k]) || (seg_out === b[k]) || (seg_out === c[k]);
        chk("no_intermediate", ok, 1);
    endtask

    initial begin
        logic [3:0] e_en;
        rst = 1'b1; score_valid = 1'b0; score_in = '0; mode_hex = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_seg", seg_out, 7'h7f);
        chk("rst_en", digit_en, 4'hf);
        chk("rst_ready", score_ready, 1);
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            e_en = ~(4'b0001 << ((i - 1) / 4));
            chk("scan_en", digit_en, e_en);
            if (i == 1) chk("first_seg", seg_out, S0);
        end

        send(14'd1234, 1'b0, lc);
        chk("ready_low_dec", lc, 15);
        check_frame({S1, S2, S3, S4}, "dec1234");

        send(14'd12000, 1'b0, lc);
        check_frame({S9, S9, S9, S9}, "sat9999");

        send(14'h2ABC, 1'b1, lc);
        chk("ready_low_hex", lc, 1);
        check_frame({S2, SA, SB, SC}, "hex2abc");

        // second request raised while busy converting 1234
        @(negedge clk);
        score_in = 14'd1234; mode_hex = 1'b0; score_valid = 1'b1;
        chk("ready_pre", score_ready, 1);
        @(posedge clk);
        @(negedge clk);
        score_valid = 1'b0;
        lc = 0;
        while (!score_ready && lc < 50) begin
            if (lc == 2) begin
                score_in = 14'd500; score_valid = 1'b1;
            end
            sample_allowed({S2, SA, SB, SC}, {S1, S2, S3, S4}, {LZ, S5, S0, S0});
            lc++;
            @(negedge clk);
        end
        chk("ready_low_busy", lc, 15);
        @(posedge clk);
        @(negedge clk);
        score_valid = 1'b0;
        chk("accepted500", score_ready, 0);
        repeat (40) begin
            sample_allowed({S2, SA, SB, SC}, {S1, S2, S3, S4}, {LZ, S5, S0, S0});
            @(negedge clk);
        end
        check_frame({LZ, S5, S0, S0}, "dec500");

        send(14'd7, 1'b0, lc);
        check_frame({LZ, LZ, LZ, S7}, "dec7");

        // reset in the middle of a conversion
        @(negedge clk);
        score_in = 14'd1234; mode_hex = 1'b0; score_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        score_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_mid", score_ready, 0);
        rst = 1'b1;
        #1;
        chk("abort_seg", seg_out, 7'h7f);
        chk("abort_en", digit_en, 4'hf);
        chk("abort_ready", score_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        check_frame({LZ, LZ, LZ, S0}, "abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
